mem: RTL

MEM -- requirements
Module: mem

---
 rtl/mem.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem.sv
// MEM pipeline stage: holds one instruction from EXE, drives the data RAM
// (synchronous, 1-cycle read latency) and forwards the result bus to WB.
module mem (
  input  logic         clk,
  input  logic         reset,
  input  logic         EXE_over,
  input  logic [154:0] EXE_MEM_bus,
  input  logic         WB_allowin,
  input  logic         cancel,
  input  logic [31:0]  dm_rdata,
  output logic         MEM_allowin,
  output logic         MEM_valid,
  output logic         MEM_over,
  output logic [118:0] MEM_WB_bus,
  output logic [31:0]  dm_addr,
  output logic [3:0]   dm_wen,
  output logic [31:0]  dm_wdata,
  output logic [4:0]   MEM_wdest,
  output logic [31:0]  MEM_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;
  logic [154:0]   r_bus;
  logic           r_valid;
  logic           r_issued;
  logic           r_rd_held;
  logic [31:0]    r_rdata;

  logic           w_inst_load, w_inst_store, w_ls_word, w_lb_sign;
  logic [31:0]    w_store_data, w_exe_result, w_lo_result, w_pc;
  logic           w_hi_write, w_lo_write, w_wen, w_data_related_en;
  logic [4:0]     w_wdest;
  logic           w_mfhi, w_mflo, w_mtc0, w_mfc0, w_syscall, w_eret;
  logic [7:0]     w_cp0r_addr;

  logic           w_cap;
  logic           w_cap_load;
  logic           w_over;
  logic           w_leave;
  logic [31:0]    w_ld_word;
  logic [7:0]     w_ld_byte;
  logic [31:0]    w_mem_result;
  logic [3:0]     w_wen_mask;

  assign {w_inst_load, w_inst_store, w_ls_word, w_lb_sign,
          w_store_data, w_exe_result, w_lo_result,
          w_hi_write, w_lo_write, w_wen, w_wdest, w_data_related_en,
          w_mfhi, w_mflo, w_mtc0, w_mfc0, w_cp0r_addr,
          w_syscall, w_eret, w_pc} = r_bus;

  assign w_cap       = EXE_over & MEM_allowin;
  assign w_cap_load  = w_cap & EXE_MEM_bus[154];
  assign w_over      = r_valid & (~w_inst_load | (r_state == S_DONE));
  assign w_leave     = w_over & WB_allowin;
  assign MEM_allowin = ~r_valid | w_leave;
  assign MEM_valid   = r_valid;
  assign MEM_over    = w_over;

  // pipeline data register, loaded whenever EXE hands over an instruction
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_bus <= EXE_MEM_bus;
    end
  end

  // stage occupancy; a flush from WB beats a simultaneous load
  always_ff @(posedge clk) begin
    if (reset || cancel) begin
      r_valid <= 1'b0;
    end else if (w_cap) begin
      r_valid <= 1'b1;
    end else if (w_leave) begin
      r_valid <= 1'b0;
    end
  end

  // load FSM next state
  always_comb begin
    w_state_nx = r_state;
    if (cancel) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nx = w_cap_load ? S_WAIT : S_IDLE;
        S_WAIT:  w_state_nx = S_DONE;
        S_DONE: begin
          if (w_cap_load) begin
            w_state_nx = S_WAIT;
          end else if (w_leave) begin
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_DONE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // load FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // RAM data is live in the first DONE cycle; hold a copy for WB stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_held <= 1'b0;
    end else begin
      r_rd_held <= (r_state == S_DONE) && (w_state_nx == S_DONE);
    end
    if ((r_state == S_DONE) && !r_rd_held) begin
      r_rdata <= dm_rdata;
    end
  end

  // one-shot store flag: a stalled store writes the RAM once
  always_ff @(posedge clk) begin
    if (reset) begin
      r_issued <= 1'b0;
    end else if (w_cap) begin
      r_issued <= 1'b0;
    end else if (dm_wen != 4'b0000) begin
      r_issued <= 1'b1;
    end
  end

  assign w_ld_word = r_rd_held ? r_rdata : dm_rdata;

  // load byte lane select
  always_comb begin
    w_ld_byte = 8'd0;
    case (w_exe_result[1:0])
      2'd0:    w_ld_byte = w_ld_word[7:0];
      2'd1:    w_ld_byte = w_ld_word[15:8];
      2'd2:    w_ld_byte = w_ld_word[23:16];
      2'd3:    w_ld_byte = w_ld_word[31:24];
      default: w_ld_byte = 8'd0;
    endcase
  end

  // result mux and store lane generation
  always_comb begin
    w_mem_result = w_exe_result;
    w_wen_mask   = 4'b0000;
    if (w_inst_load) begin
      if (w_ls_word) begin
        w_mem_result = w_ld_word;
      end else if (w_lb_sign) begin
        w_mem_result = {{24{w_ld_byte[7]}}, w_ld_byte};
      end else begin
        w_mem_result = {24'd0, w_ld_byte};
      end
    end else begin
      w_mem_result = w_exe_result;
    end
    if (w_ls_word) begin
      w_wen_mask = 4'b1111;
    end else begin
      w_wen_mask = 4'b0001 << w_exe_result[1:0];
    end
  end

  assign dm_addr  = w_exe_result;
  assign dm_wdata = w_ls_word ? w_store_data : {4{w_store_data[7:0]}};
  assign dm_wen   = (r_valid & w_inst_store & ~r_issued & ~cancel & ~reset)
                    ? w_wen_mask : 4'b0000;

  assign MEM_WB_bus = {w_wen, w_wdest, w_data_related_en, w_mem_result,
                       w_lo_result, w_hi_write, w_lo_write,
                       w_mfhi, w_mflo, w_mtc0, w_mfc0, w_cp0r_addr,
                       w_syscall, w_eret, w_pc};

  assign MEM_wdest = w_wdest & {5{r_valid}};
  assign MEM_pc    = w_pc;

endmodule
